pipe_stall_ctrl: RTL
====================

// Module: pipe_stall_ctrl
// PURPOSE
// Consumer side of the load-use hazard interface: owns the IF/ID pipeline register and
// turns stall requests into fetch/pipeline enables. Sits between fetch and decode.
// Arbitrates load-use stall (hazard unit), branch/JALR redirect (EX) and data-memory busy.
// Latches a redirect that arrives while memory is busy and replays it afterwards.
// PARAMETERS
// XLEN   32            datapath/PC width
// NOP    32'h00000013  bubble instruction (addi x0,x0,0)
// CNT_W  16            width of saturating performance counters
// PORTS
// clk            in   1      clock, rising edge
// rst            in   1      async reset, active-low
// if_pc          in   XLEN   PC of fetched instruction
// if_instr       in   32     fetched instruction
// if_valid       in   1      fetch output valid
// load_use_stall in   1      hazard unit request (comb., refers to instr in ID)
// redirect_valid in   1      EX resolved taken branch/JALR
// redirect_pc    in   XLEN   redirect target
// mem_busy       in   1      data memory not ready; freeze pipeline
// id_pc          out  XLEN   IF/ID register: PC
// id_instr       out  32     IF/ID register: instruction
// id_valid       out  1      IF/ID register: valid
// pc_hold        out  1      fetch PC must not advance
// pc_load        out  1      fetch PC loads pc_load_addr this edge
// pc_load_addr   out  XLEN   new fetch PC
// idex_bubble    out  1      ID/EX loads NOP, valid=0
// idex_hold      out  1      ID/EX keeps contents
// exmem_hold     out  1      EX/MEM keeps contents
// stall_cnt      out  CNT_W  cycles spent stalled (saturating)
// flush_cnt      out  CNT_W  redirects applied (saturating)
// BEHAVIOUR
// Reset: id_pc=0, id_instr=NOP, id_valid=0, state=RUN, pending=0, counters=0;
//  all comb. outputs deasserted while state=RUN and inputs idle.
// Priority per cycle: mem_busy > redirect (live or pending) > load_use_stall > advance.
// States: RUN, LD_BUBBLE, MEM_WAIT, REPLAY.
// RUN: mem_busy -> MEM_WAIT (freeze this cycle); redirect_valid -> flush; load_use_stall ->
//  LD_BUBBLE; else IF/ID <= {if_pc,if_instr,if_valid}.
// Freeze: pc_hold=idex_hold=exmem_hold=1, IF/ID unchanged, stall_cnt++.
// Flush: pc_load=1, pc_load_addr=redirect_pc, IF/ID <= {0,NOP,0}, idex_bubble=1,
//  flush_cnt++; next state RUN. pc_hold=0.
// Load-use: pc_hold=1, IF/ID unchanged, idex_bubble=1, stall_cnt++; -> LD_BUBBLE.
// LD_BUBBLE: load_use_stall masked (exactly one bubble per load); redirect/mem_busy still
//  honoured per priority; otherwise advance and -> RUN.
// MEM_WAIT: freeze while mem_busy. redirect_valid seen during freeze -> pending=1,
//  pending_pc=redirect_pc (first one wins). mem_busy=0: pending -> REPLAY else RUN, advance.
// REPLAY: flush using pending_pc, clear pending, -> RUN (live redirect_valid ignored; EX
//  holds a bubble). mem_busy in REPLAY: freeze, stay in REPLAY.
// Simultaneous load_use_stall+redirect: redirect wins, no bubble count.
// Counters saturate at all-ones, never wrap. Async reset mid-stall returns to reset state
//  immediately; pending redirect discarded.
// STRUCTURE
// Shared header: NOP encoding, opcode defines (`I_TYPE_LOAD etc.), state encodings.
// One sub-module: sat_counter (CNT_W, inc, async active-low reset), instanced twice.
// FSM: separate state register block and comb. next-state/output block.
// TESTING
// Straight-line flow, no stalls -> IF/ID tracks if_* one cycle later, all holds 0.
// load_use_stall 1 cycle at PC 0x10 -> pc_hold=1, idex_bubble=1 once, id_pc stays 0x10,
//  stall_cnt=1; re-asserted in LD_BUBBLE -> ignored.
// redirect_valid, redirect_pc=0x200 -> pc_load=1, addr=0x200, id_valid=0 next, flush_cnt=1.
// mem_busy 4 cycles with redirect 0x300 on cycle 2 -> 4 freeze cycles, then REPLAY:
//  pc_load to 0x300, flush_cnt=1, stall_cnt=4.
// load_use_stall+redirect same cycle -> flush only, stall_cnt unchanged.
// Drive stall_cnt past 2^CNT_W-1 -> holds 0xFFFF; rst low mid MEM_WAIT -> reset values.

Source files
------------

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared definitions for the IF/ID stall controller: instruction encodings,
// FSM state encoding and the per-cycle pipeline action.
package pipe_stall_ctrl_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = {12'd0, 5'd0, 3'b000, 5'd0, OPC_OP_IMM};

  typedef enum logic [1:0] {
    ST_RUN,
    ST_LD_BUBBLE,
    ST_MEM_WAIT,
    ST_REPLAY
  } state_e;

  typedef enum logic [1:0] {
    ACT_ADVANCE,
    ACT_FREEZE,
    ACT_FLUSH,
    ACT_LD_STALL
  } act_e;

  function automatic logic is_redirect_op(input logic [31:0] instr);
    return (instr[6:0] == OPC_BRANCH) || (instr[6:0] == OPC_JALR);
  endfunction

  function automatic logic is_load_op(input logic [31:0] instr);
    return instr[6:0] == OPC_LOAD;
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// IF/ID register owner: arbitrates memory freeze, branch redirect and load-use
// stall into fetch/pipeline enables, replaying redirects that land during a freeze.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter logic [31:0] NOP   = NOP_INSTR,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  if_pc,
  input  logic [31:0]      if_instr,
  input  logic             if_valid,
  input  logic             load_use_stall,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  input  logic             mem_busy,
  output logic [XLEN-1:0]  id_pc,
  output logic [31:0]      id_instr,
  output logic             id_valid,
  output logic             pc_hold,
  output logic             pc_load,
  output logic [XLEN-1:0]  pc_load_addr,
  output logic             idex_bubble,
  output logic             idex_hold,
  output logic             exmem_hold,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  state_e          state_q, state_d;
  act_e            act;
  logic            pending_q;
  logic [XLEN-1:0] pending_pc_q;
  logic            replay_flush;
  logic            stall_inc;
  logic            flush_inc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Release from MEM_WAIT with a captured redirect advances once and lets
  // REPLAY issue the flush; live redirects on that cycle lose to the pending one.
  always_comb begin
    state_d = ST_RUN;
    act     = ACT_ADVANCE;
    case (state_q)
      ST_REPLAY: begin
        if (mem_busy) begin
          act     = ACT_FREEZE;
          state_d = ST_REPLAY;
        end else begin
          act     = ACT_FLUSH;
        end
      end
      default: begin
        if (mem_busy) begin
          act     = ACT_FREEZE;
          state_d = ST_MEM_WAIT;
        end else if ((state_q == ST_MEM_WAIT) && pending_q) begin
          state_d = ST_REPLAY;
        end else if (redirect_valid) begin
          act     = ACT_FLUSH;
        end else if (load_use_stall && (state_q != ST_LD_BUBBLE)) begin
          act     = ACT_LD_STALL;
          state_d = ST_LD_BUBBLE;
        end
      end
    endcase
  end

  assign replay_flush = (act == ACT_FLUSH) && (state_q == ST_REPLAY);
  assign stall_inc    = (act == ACT_FREEZE) || (act == ACT_LD_STALL);
  assign flush_inc    = (act == ACT_FLUSH);

  always_comb begin
    pc_hold      = (act == ACT_FREEZE) || (act == ACT_LD_STALL);
    pc_load      = (act == ACT_FLUSH);
    pc_load_addr = '0;
    if (act == ACT_FLUSH) begin
      pc_load_addr = replay_flush ? pending_pc_q : redirect_pc;
    end
    idex_bubble  = (act == ACT_FLUSH) || (act == ACT_LD_STALL);
    idex_hold    = (act == ACT_FREEZE);
    exmem_hold   = (act == ACT_FREEZE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_pc        <= '0;
      id_instr     <= NOP;
      id_valid     <= 1'b0;
      pending_q    <= 1'b0;
      pending_pc_q <= '0;
    end else begin
      case (act)
        ACT_ADVANCE: begin
          id_pc    <= if_pc;
          id_instr <= if_instr;
          id_valid <= if_valid;
        end
        ACT_FLUSH: begin
          id_pc    <= '0;
          id_instr <= NOP;
          id_valid <= 1'b0;
        end
        default: ;
      endcase
      if (replay_flush) begin
        pending_q <= 1'b0;
      end else if ((act == ACT_FREEZE) && redirect_valid && !pending_q) begin
        pending_q    <= 1'b1;
        pending_pc_q <= redirect_pc;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_inc),
    .cnt (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush_inc),
    .cnt (flush_cnt)
  );

endmodule
